spi_master: RTL and testbench

- SPI bus master that originates frames to the board's SPI slave devices.
- Generates SCK from i_clk by a programmable divider and drives SSEL_n and MOSI. Data goes out MSB first and MISO is shifted in.
- Returns the received word to the host logic with a one-cycle valid strobe.
- Sits between the on-chip controller and the external SPI bus, fully synchronous to i_clk. The bus uses SCK idle low: the slave shifts MISO on the SCK rising edge and samples MOSI on the SCK falling edge.

---
 rtl/spi_master_if.sv | 34 +++
 rtl/spi_master.sv | 177 +++++++++++++++++
 tb/tb_spi_master.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// SPI master bus bundle: host request/response signals plus the external SPI pins.
//   i_start     host -> master  frame request
//   i_tx_data   host -> master  word to transmit
//   o_rx_data   master -> host  last received word
//   o_rx_valid  master -> host  one-cycle strobe, o_rx_data updated
//   o_busy      master -> host  master not idle
//   o_sck       master -> pin   SPI clock, idle low
//   o_ssel_n    master -> pin   slave select, active low
//   o_mosi      master -> pin   serial data out
//   i_miso      pin -> master   serial data in (already synchronised)
// Modport 'slave' is taken by the spi_master block; 'master' is the host/board side.
interface spi_master_if #(
    parameter int unsigned FRAME_BITS = 16
);
    logic                  i_start;
    logic [FRAME_BITS-1:0] i_tx_data;
    logic [FRAME_BITS-1:0] o_rx_data;
    logic                  o_rx_valid;
    logic                  o_busy;
    logic                  o_sck;
    logic                  o_ssel_n;
    logic                  o_mosi;
    logic                  i_miso;

    modport master (
        output i_start, i_tx_data, i_miso,
        input  o_rx_data, o_rx_valid, o_busy, o_sck, o_ssel_n, o_mosi
    );

    modport slave (
        input  i_start, i_tx_data, i_miso,
        output o_rx_data, o_rx_valid, o_busy, o_sck, o_ssel_n, o_mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI bus master: sends FRAME_BITS words MSB first on MOSI while shifting in MISO,
// SCK idle low, slave shifts on SCK rise and master samples MISO on SCK fall.
// Ports:
//   i_clk  system clock, all logic on its rising edge
//   i_rst  synchronous active-high reset
//   bus    spi_master_if.slave: host handshake (start/tx/rx/valid/busy) and SPI pins
// All interface outputs are registered.
module spi_master #(
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned GAP_CYC    = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    spi_master_if.slave  bus
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_BITS);
    localparam int unsigned CNT_M1  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CNT_MAX = (CNT_M1 > GAP_CYC) ? CNT_M1 : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [DIV_W-1:0]      div_q,      div_d;
    logic [BIT_W-1:0]      bit_q,      bit_d;
    logic [FRAME_BITS-1:0] tx_sr_q,    tx_sr_d;
    logic [FRAME_BITS-1:0] rx_sr_q,    rx_sr_d;
    logic [FRAME_BITS-1:0] rx_data_q,  rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  busy_q,     busy_d;
    logic                  sck_q,      sck_d;
    logic                  ssel_n_q,   ssel_n_d;
    logic                  mosi_q,     mosi_d;

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            ssel_n_q   <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            sck_q      <= sck_d;
            ssel_n_q   <= ssel_n_d;
            mosi_q     <= mosi_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        ssel_n_d   = ssel_n_q;
        mosi_d     = mosi_q;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    tx_sr_d  = bus.i_tx_data;
                    mosi_d   = bus.i_tx_data[FRAME_BITS-1];
                    ssel_n_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end

            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising edge k: bit_q equals k; the MSB is already out for k=0
                        if (bit_q != '0) begin
                            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                            mosi_d  = tx_sr_q[FRAME_BITS-2];
                        end
                    end else begin
                        // Falling edge: capture MISO, finish after the last bit
                        rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], bus.i_miso};
                        if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                            bit_d   = '0;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cnt_d      = '0;
                    ssel_n_d   = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    state_d    = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.o_rx_data  = rx_data_q;
    assign bus.o_rx_valid = rx_valid_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_sck      = sck_q;
    assign bus.o_ssel_n   = ssel_n_q;
    assign bus.o_mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (8-bit/div2, 8-bit/div1, 16-bit defaults)
// with a behavioural SPI slave per instance and a shared receive scoreboard.
module tb_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_if #(.FRAME_BITS(8))  bus_a ();
    spi_master_if #(.FRAME_BITS(8))  bus_b ();
    spi_master_if #(.FRAME_BITS(16)) bus_c ();

    spi_master #(.FRAME_BITS(8), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .GAP_CYC(2)) u_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a)
    );
    spi_master #(.FRAME_BITS(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP_CYC(2)) u_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b)
    );
    spi_master u_c (
        .i_clk(clk), .i_rst(rst), .bus(bus_c)
    );

    // Per-instance constants: frame bits, SCK half period
    int fbits [3];
    int divs  [3];

    // Stimulus side
    logic        start_r    [3];
    logic [15:0] tx_r       [3];
    logic        miso_r     [3];
    logic [15:0] slave_word [3];

    // Observed DUT outputs
    logic        sck  [3];
    logic        ssel [3];
    logic        mosi [3];
    logic        busy [3];
    logic        vld  [3];
    logic [15:0] rxd  [3];

    assign bus_a.i_start   = start_r[0];
    assign bus_a.i_tx_data = tx_r[0][7:0];
    assign bus_a.i_miso    = miso_r[0];
    assign bus_b.i_start   = start_r[1];
    assign bus_b.i_tx_data = tx_r[1][7:0];
    assign bus_b.i_miso    = miso_r[1];
    assign bus_c.i_start   = start_r[2];
    assign bus_c.i_tx_data = tx_r[2];
    assign bus_c.i_miso    = miso_r[2];

    assign sck[0] = bus_a.o_sck;  assign ssel[0] = bus_a.o_ssel_n;  assign mosi[0] = bus_a.o_mosi;
    assign busy[0] = bus_a.o_busy; assign vld[0] = bus_a.o_rx_valid; assign rxd[0] = {8'h00, bus_a.o_rx_data};
    assign sck[1] = bus_b.o_sck;  assign ssel[1] = bus_b.o_ssel_n;  assign mosi[1] = bus_b.o_mosi;
    assign busy[1] = bus_b.o_busy; assign vld[1] = bus_b.o_rx_valid; assign rxd[1] = {8'h00, bus_b.o_rx_data};
    assign sck[2] = bus_c.o_sck;  assign ssel[2] = bus_c.o_ssel_n;  assign mosi[2] = bus_c.o_mosi;
    assign busy[2] = bus_c.o_busy; assign vld[2] = bus_c.o_rx_valid; assign rxd[2] = bus_c.o_rx_data;

    // Scoreboard of expected received words
    typedef struct {
        int          id;
        logic [15:0] data;
    } sb_t;
    sb_t sb_q [$];
    sb_t sb_e;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Slave model / bus monitor state
    int          low_cnt   [3];
    int          last_low  [3];
    int          pulses    [3];
    int          falls     [3];
    int          hi_len    [3];
    int          hi_bad    [3];
    int          frames    [3];
    int          starts    [3];
    int          gap_cnt   [3];
    int          last_gap  [3];
    int          post_busy [3];
    int          idle_tog  [3];
    int          valid_cnt [3];
    logic [15:0] slave_tx  [3];
    logic [15:0] slave_rx  [3];
    logic [15:0] last_rx   [3];
    logic        prev_ssel [3];
    logic        prev_sck  [3];

    // Sampled on the falling clk edge, away from the DUT's active edge
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (vld[d] === 1'b1) begin
                valid_cnt[d]++;
                check("valid_at_ssel_rise", {31'b0, (ssel[d] === 1'b1) && !prev_ssel[d]}, 1);
                if (sb_q.size() == 0) begin
                    check("valid_unexpected", d, 99);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_dut_id", d, sb_e.id);
                    check("sb_rx_data", rxd[d], sb_e.data);
                end
            end
            if (ssel[d] === 1'b0) begin
                if (prev_ssel[d]) begin
                    starts[d]++;
                    last_gap[d] = gap_cnt[d];
                    low_cnt[d]  = 0;
                    pulses[d]   = 0;
                    falls[d]    = 0;
                    hi_len[d]   = 0;
                    hi_bad[d]   = 0;
                    slave_rx[d] = '0;
                    slave_tx[d] = slave_word[d];
                end
                low_cnt[d]++;
                if (sck[d] === 1'b1 && !prev_sck[d]) begin
                    pulses[d]++;
                    hi_len[d]   = 0;
                    miso_r[d]   = slave_tx[d][fbits[d]-1];
                    slave_tx[d] = slave_tx[d] << 1;
                end
                if (sck[d] === 1'b1) hi_len[d]++;
                if (sck[d] === 1'b0 && prev_sck[d]) begin
                    falls[d]++;
                    slave_rx[d] = {slave_rx[d][14:0], mosi[d]};
                    if (hi_len[d] != divs[d]) hi_bad[d]++;
                end
            end else if (ssel[d] === 1'b1) begin
                if (!prev_ssel[d]) begin
                    frames[d]++;
                    last_low[d]  = low_cnt[d];
                    last_rx[d]   = slave_rx[d];
                    gap_cnt[d]   = 0;
                    post_busy[d] = 0;
                end
                gap_cnt[d]++;
                if (busy[d] === 1'b1) post_busy[d]++;
                if ((sck[d] === 1'b1) != prev_sck[d]) idle_tog[d]++;
            end
            prev_ssel[d] = (ssel[d] !== 1'b0);
            prev_sck[d]  = (sck[d] === 1'b1);
        end
    end

    function automatic int get_cnt(input int which, input int d);
        case (which)
            0:       return frames[d];
            1:       return starts[d];
            2:       return falls[d];
            default: return pulses[d];
        endcase
    endfunction

    // Bounded wait for a monitor counter to reach a target
    task automatic wait_for(input string nm, input int which, input int d, input int target);
        int n = 0;
        while (get_cnt(which, d) < target && n < 5000) begin
            @(posedge clk); #2;
            n++;
        end
        check({nm, "_reached"}, {31'b0, get_cnt(which, d) >= target}, 1);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy[d] !== 1'b0 && n < 5000) begin
            @(posedge clk); #2;
            n++;
        end
        check("busy_drop_reached", {31'b0, busy[d] === 1'b0}, 1);
    endtask

    task automatic send(input int d, input logic [15:0] data, input logic [15:0] sw);
        @(posedge clk); #2;
        slave_word[d] = sw;
        tx_r[d]       = data;
        start_r[d]    = 1'b1;
        @(posedge clk); #2;
        start_r[d]    = 1'b0;
    endtask

    typedef struct {
        logic [15:0] tx;
        logic [15:0] miso;
        logic [15:0] exp_mosi;
        logic [15:0] exp_rx;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int f0, s0, v0;
        fbits = '{8, 8, 16};
        divs  = '{2, 1, 4};
        for (int d = 0; d < 3; d++) begin
            start_r[d] = 1'b0; tx_r[d] = '0; miso_r[d] = 1'b0; slave_word[d] = '0;
            low_cnt[d] = 0; last_low[d] = 0; pulses[d] = 0; falls[d] = 0; hi_len[d] = 0;
            hi_bad[d] = 0; frames[d] = 0; starts[d] = 0; gap_cnt[d] = 0; last_gap[d] = 0;
            post_busy[d] = 0; idle_tog[d] = 0; valid_cnt[d] = 0;
            slave_tx[d] = '0; slave_rx[d] = '0; last_rx[d] = '0;
            prev_ssel[d] = 1'b1; prev_sck[d] = 1'b0;
        end
        vecs[0] = '{16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
        vecs[1] = '{16'h0000, 16'h00FF, 16'h0000, 16'h00FF};
        vecs[2] = '{16'h00FF, 16'h0000, 16'h00FF, 16'h0000};
        vecs[3] = '{16'h005A, 16'h00C3, 16'h005A, 16'h00C3};
        vecs[4] = '{16'h0081, 16'h007E, 16'h0081, 16'h007E};

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_ssel_n", {31'b0, ssel[0]}, 1);
        check("rst_sck",    {31'b0, sck[0]}, 0);
        check("rst_mosi",   {31'b0, mosi[0]}, 0);
        check("rst_busy",   {31'b0, busy[0]}, 0);
        check("rst_valid",  {31'b0, vld[0]}, 0);
        check("rst_rx_data", rxd[0], 0);
        check("rst_ssel_n_c", {31'b0, ssel[2]}, 1);
        rst = 1'b0;

        // Table of single frames on the 8-bit / div-2 instance
        for (int i = 0; i < 5; i++) begin
            f0 = frames[0];
            v0 = valid_cnt[0];
            sb_q.push_back('{0, vecs[i].exp_rx});
            send(0, vecs[i].tx, vecs[i].miso);
            wait_for("vec_frame", 0, 0, f0 + 1);
            check("vec_mosi_word", last_rx[0], vecs[i].exp_mosi);
            check("vec_ssel_low_cycles", last_low[0], 34);
            check("vec_sck_pulses", pulses[0], 8);
            check("vec_sck_high_len_errs", hi_bad[0], 0);
            wait_idle(0);
            check("vec_busy_in_gap", post_busy[0], 2);
            check("vec_valid_cycles", valid_cnt[0], v0 + 1);
        end

        // Start requests while busy are ignored
        f0 = frames[0];
        s0 = starts[0];
        sb_q.push_back('{0, 16'h003C});
        send(0, 16'h00A5, 16'h003C);
        wait_for("rej_start", 1, 0, s0 + 1);
        wait_for("rej_pulses", 3, 0, 3);
        tx_r[0] = 16'h00FF; start_r[0] = 1'b1;
        check("rej_busy_in_shift", {31'b0, busy[0]}, 1);
        @(posedge clk); #2;
        start_r[0] = 1'b0;
        wait_for("rej_frame", 0, 0, f0 + 1);
        start_r[0] = 1'b1;
        check("rej_busy_in_gap", {31'b0, busy[0]}, 1);
        @(posedge clk); #2;
        start_r[0] = 1'b0;
        wait_idle(0);
        repeat (20) @(posedge clk);
        #2;
        check("rej_frame_count", frames[0], f0 + 1);
        check("rej_start_count", starts[0], s0 + 1);
        check("rej_mosi_word", last_rx[0], 16'h00A5);
        check("rej_busy_in_gap_cycles", post_busy[0], 2);

        // Back-to-back with start held high
        f0 = frames[0];
        s0 = starts[0];
        sb_q.push_back('{0, 16'h0096});
        sb_q.push_back('{0, 16'h0096});
        @(posedge clk); #2;
        slave_word[0] = 16'h0096; tx_r[0] = 16'h0001; start_r[0] = 1'b1;
        wait_for("b2b_start1", 1, 0, s0 + 1);
        tx_r[0] = 16'h0080;
        wait_for("b2b_frame1", 0, 0, f0 + 1);
        check("b2b_mosi_first", last_rx[0], 16'h0001);
        wait_for("b2b_start2", 1, 0, s0 + 2);
        start_r[0] = 1'b0;
        check("b2b_ssel_high_gap", last_gap[0], 3);
        wait_for("b2b_frame2", 0, 0, f0 + 2);
        check("b2b_mosi_second", last_rx[0], 16'h0080);
        wait_idle(0);
        repeat (20) @(posedge clk);
        #2;
        check("b2b_frame_count", frames[0], f0 + 2);

        // CLK_DIV=1 instance: SCK toggles every cycle
        f0 = frames[1];
        sb_q.push_back('{1, 16'h0000});
        send(1, 16'h00FF, 16'h0000);
        wait_for("div1_frame", 0, 1, f0 + 1);
        check("div1_mosi_word", last_rx[1], 16'h00FF);
        check("div1_ssel_low_cycles", last_low[1], 18);
        check("div1_sck_pulses", pulses[1], 8);
        check("div1_sck_falls", falls[1], 8);
        check("div1_sck_high_len_errs", hi_bad[1], 0);
        wait_idle(1);

        // Reset in the middle of a frame
        s0 = starts[0];
        v0 = valid_cnt[0];
        send(0, 16'h00FF, 16'h003C);
        wait_for("mid_rst_start", 1, 0, s0 + 1);
        wait_for("mid_rst_falls", 2, 0, 3);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("mid_rst_ssel_n",  {31'b0, ssel[0]}, 1);
        check("mid_rst_sck",     {31'b0, sck[0]}, 0);
        check("mid_rst_mosi",    {31'b0, mosi[0]}, 0);
        check("mid_rst_busy",    {31'b0, busy[0]}, 0);
        check("mid_rst_rx_data", rxd[0], 0);
        check("mid_rst_valid",   {31'b0, vld[0]}, 0);
        repeat (40) @(posedge clk);
        #2;
        check("mid_rst_no_valid", valid_cnt[0], v0);
        f0 = frames[0];
        sb_q.push_back('{0, 16'h003C});
        send(0, 16'h00A5, 16'h003C);
        wait_for("post_rst_frame", 0, 0, f0 + 1);
        check("post_rst_mosi_word", last_rx[0], 16'h00A5);
        check("post_rst_ssel_low", last_low[0], 34);
        wait_idle(0);

        // Default parameters, 16-bit frame
        f0 = frames[2];
        sb_q.push_back('{2, 16'hBEEF});
        send(2, 16'h8001, 16'hBEEF);
        wait_for("def_frame", 0, 2, f0 + 1);
        check("def_mosi_word", last_rx[2], 16'h8001);
        check("def_ssel_low_cycles", last_low[2], 132);
        check("def_sck_pulses", pulses[2], 16);
        check("def_sck_high_len_errs", hi_bad[2], 0);
        wait_idle(2);
        check("def_busy_in_gap", post_busy[2], 4);

        // Global properties
        repeat (5) @(posedge clk);
        #2;
        for (int d = 0; d < 3; d++) check("sck_toggle_while_deselected", idle_tog[d], 0);
        check("sb_leftover", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
